// File: rtl/l2_wb_receiver.sv
// ---------------------------------------------------------------------------
// l2_wb_receiver
//
// L2-side responder for the DL1 write-buffer handshake. Dirty-word packets
// from DL1 are captured into a small circular FIFO (with coalescing of a
// repeated write to the newest entry), drained one at a time into the L2
// data-array write port, and searched combinationally so that an L2 lookup
// never returns data older than a buffered write.
//
// Ports
//   clk_l2         in   L2 clock, all state changes on its rising edge
//   rst            in   synchronous active-high reset
//   wb_req         in   DL1 packet valid (level, held until acknowledged)
//   wb_data        in   {word_addr[DATA_LENGTH-1:BYTE_OFFSET], data}
//   wb_ack         out  one-cycle acceptance pulse, cycle after capture
//   full_flag      out  registered, count == WB_DEPTH
//   wb_empty       out  registered, count == 0
//   l2_wr_valid    out  head entry presented to the L2 array
//   l2_wr_addr     out  head byte address {word_addr, BYTE_OFFSET zeros}
//   l2_wr_data     out  head data
//   l2_wr_ready    in   L2 array takes the head this cycle
//   rd_check_addr  in   L2 lookup byte address
//   rd_hit         out  some valid entry matches the lookup word address
//   rd_hit_data    out  data of the newest matching entry, 0 when no hit
//   dbg_state      out  accept FSM state (0 = IDLE, 1 = ACK)
//   dbg_count      out  number of buffered entries
//
// Handshakes
//   DL1 side : a packet is taken on the rising edge where the FSM is IDLE,
//              wb_req is high and full_flag is low. wb_ack is high for the
//              following cycle only; wb_req is ignored during that cycle and
//              the initiator may drop or replace it afterwards.
//   L2 side  : l2_wr_valid/ready. The head is popped on any edge where both
//              are high. While l2_wr_valid is high the head address/data do
//              not change, and valid stays high until the head is taken.
// ---------------------------------------------------------------------------
module l2_wb_receiver #(
  parameter int DATA_LENGTH = 32,
  parameter int BYTE_OFFSET = 2,
  parameter int WB_DEPTH    = 4
) (
  input  logic                                   clk_l2,
  input  logic                                   rst,
  input  logic                                   wb_req,
  input  logic [2*DATA_LENGTH-BYTE_OFFSET-1:0]   wb_data,
  output logic                                   wb_ack,
  output logic                                   full_flag,
  output logic                                   wb_empty,
  output logic                                   l2_wr_valid,
  output logic [DATA_LENGTH-1:0]                 l2_wr_addr,
  output logic [DATA_LENGTH-1:0]                 l2_wr_data,
  input  logic                                   l2_wr_ready,
  input  logic [DATA_LENGTH-1:0]                 rd_check_addr,
  output logic                                   rd_hit,
  output logic [DATA_LENGTH-1:0]                 rd_hit_data,
  output logic                                   dbg_state,
  output logic [$clog2(WB_DEPTH):0]              dbg_count
);

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WA_W  = DATA_LENGTH - BYTE_OFFSET;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } acc_state_t;

  acc_state_t state, state_next;

  // Entry storage; contents are not reset, validity comes from the pointers.
  logic [WA_W-1:0]        addr_mem [WB_DEPTH];
  logic [DATA_LENGTH-1:0] data_mem [WB_DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] newest_ptr;
  logic [PTR_W-1:0] fwd_idx;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  logic [WA_W-1:0]        cap_addr;
  logic [DATA_LENGTH-1:0] cap_data;
  logic                   accept;
  logic                   merge;
  logic                   push;
  logic                   pop;

  // The byte-offset bits of the lookup address never take part in a match.
  logic [BYTE_OFFSET-1:0] unused_rd_lsbs;
  assign unused_rd_lsbs = rd_check_addr[BYTE_OFFSET-1:0];

  assign cap_addr   = wb_data[2*DATA_LENGTH-BYTE_OFFSET-1:DATA_LENGTH];
  assign cap_data   = wb_data[DATA_LENGTH-1:0];
  assign newest_ptr = wr_ptr - PTR_W'(1);

  // -------------------------------------------------------------------------
  // Accept FSM: IDLE captures, ACK is the single acknowledge cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        // full_flag is the registered flag, so a pop in the same cycle does
        // not open a slot until the next cycle.
        if (wb_req && !full_flag) begin
          accept     = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign wb_ack    = (state == ACK);
  assign dbg_state = (state == ACK);

  // Coalesce into the newest entry only when it cannot be the head; with a
  // single entry the head may be leaving through the L2 port this cycle.
  assign merge = accept && (count >= CNT_W'(2)) &&
                 (addr_mem[newest_ptr] == cap_addr);
  assign push  = accept && !merge;
  assign pop   = l2_wr_valid && l2_wr_ready;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // -------------------------------------------------------------------------
  // Control state: FSM, pointers, count and registered flags.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_l2) begin
    if (rst) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      full_flag <= 1'b0;
      wb_empty  <= 1'b1;
    end else begin
      state <= state_next;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count     <= count_next;
      full_flag <= (count_next == CNT_W'(WB_DEPTH));
      wb_empty  <= (count_next == '0);
    end
  end

  // -------------------------------------------------------------------------
  // Entry writes. A merge never targets the head (count >= 2), so it cannot
  // collide with the entry being drained.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_l2) begin
    if (!rst) begin
      if (push) begin
        addr_mem[wr_ptr] <= cap_addr;
        data_mem[wr_ptr] <= cap_data;
      end
      if (merge) begin
        data_mem[newest_ptr] <= cap_data;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Drain port: the head entry.
  // -------------------------------------------------------------------------
  assign l2_wr_valid = !wb_empty;
  assign l2_wr_addr  = {addr_mem[rd_ptr], {BYTE_OFFSET{1'b0}}};
  assign l2_wr_data  = data_mem[rd_ptr];
  assign dbg_count   = count;

  // -------------------------------------------------------------------------
  // Forwarding: walk from head towards tail so a later (newer) match
  // overrides an older one. Uses current state only, so an entry popped this
  // cycle still forwards and a packet captured this cycle does not yet.
  // -------------------------------------------------------------------------
  always_comb begin
    rd_hit      = 1'b0;
    rd_hit_data = '0;
    fwd_idx     = rd_ptr;
    for (int k = 0; k < WB_DEPTH; k++) begin
      fwd_idx = rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < count) &&
          (addr_mem[fwd_idx] == rd_check_addr[DATA_LENGTH-1:BYTE_OFFSET])) begin
        rd_hit      = 1'b1;
        rd_hit_data = data_mem[fwd_idx];
      end
    end
  end

endmodule

// File: tb/tb_l2_wb_receiver.sv
// ---------------------------------------------------------------------------
// tb_l2_wb_receiver
//
// Self-checking bench for l2_wb_receiver. A queue-based model of the write
// buffer advances on every rising edge from the bench inputs; a compare
// process checks every DUT output against the model on every falling edge.
// Directed scenarios add literal expectations, followed by a randomized
// phase with random requests, random drain back-pressure and rare resets.
// ---------------------------------------------------------------------------
module tb_l2_wb_receiver;

  localparam int DL    = 32;
  localparam int BO    = 2;
  localparam int DEPTH = 4;
  localparam int WA    = DL - BO;

  // ---------------- clock / reset ----------------
  logic clk_l2 = 1'b0;
  always #5 clk_l2 = ~clk_l2;

  logic              rst;
  logic              wb_req;
  logic [2*DL-BO-1:0] wb_data;
  logic              wb_ack;
  logic              full_flag;
  logic              wb_empty;
  logic              l2_wr_valid;
  logic [DL-1:0]     l2_wr_addr;
  logic [DL-1:0]     l2_wr_data;
  logic              l2_wr_ready;
  logic [DL-1:0]     rd_check_addr;
  logic              rd_hit;
  logic [DL-1:0]     rd_hit_data;
  logic              dbg_state;
  logic [2:0]        dbg_count;

  l2_wb_receiver #(
    .DATA_LENGTH(DL),
    .BYTE_OFFSET(BO),
    .WB_DEPTH(DEPTH)
  ) dut (
    .clk_l2        (clk_l2),
    .rst           (rst),
    .wb_req        (wb_req),
    .wb_data       (wb_data),
    .wb_ack        (wb_ack),
    .full_flag     (full_flag),
    .wb_empty      (wb_empty),
    .l2_wr_valid   (l2_wr_valid),
    .l2_wr_addr    (l2_wr_addr),
    .l2_wr_data    (l2_wr_data),
    .l2_wr_ready   (l2_wr_ready),
    .rd_check_addr (rd_check_addr),
    .rd_hit        (rd_hit),
    .rd_hit_data   (rd_hit_data),
    .dbg_state     (dbg_state),
    .dbg_count     (dbg_count)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Buffer as a pair of queues, front = oldest entry.
  logic [WA-1:0] exp_addr_q[$];
  logic [DL-1:0] exp_q[$];
  bit            ack_due    = 1'b0;
  bit            model_live = 1'b0;

  logic [DL-1:0] drain_addr_log[$];
  logic [DL-1:0] drain_data_log[$];
  bit            full_seen = 1'b0;

  initial begin : model_update
    forever begin
      bit            acc;
      bit            pp;
      bit            mg;
      logic [WA-1:0] a;
      @(posedge clk_l2);
      if (rst) begin
        exp_addr_q.delete();
        exp_q.delete();
        ack_due    = 1'b0;
        model_live = 1'b1;
      end else if (model_live) begin
        a   = wb_data[2*DL-BO-1:DL];
        acc = !ack_due && wb_req && (exp_q.size() < DEPTH);
        pp  = (exp_q.size() > 0) && l2_wr_ready;
        mg  = acc && (exp_q.size() >= 2) && (exp_addr_q[exp_addr_q.size()-1] == a);
        if (mg) exp_q[exp_q.size()-1] = wb_data[DL-1:0];
        if (pp) begin
          void'(exp_addr_q.pop_front());
          void'(exp_q.pop_front());
        end
        if (acc && !mg) begin
          exp_addr_q.push_back(a);
          exp_q.push_back(wb_data[DL-1:0]);
        end
        ack_due = acc;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : compare
    forever begin
      bit            eh;
      logic [DL-1:0] ed;
      @(negedge clk_l2);
      if (model_live) begin
        check("wb_ack", wb_ack, ack_due);
        check("dbg_state", dbg_state, ack_due);
        check("full_flag", full_flag, exp_q.size() == DEPTH);
        check("wb_empty", wb_empty, exp_q.size() == 0);
        check("l2_wr_valid", l2_wr_valid, exp_q.size() != 0);
        check("count", dbg_count, exp_q.size());
        if (exp_q.size() != 0) begin
          check("l2_wr_addr", l2_wr_addr, {exp_addr_q[0], 2'b00});
          check("l2_wr_data", l2_wr_data, exp_q[0]);
        end
        eh = 1'b0;
        ed = '0;
        for (int i = 0; i < exp_q.size(); i++) begin
          if (exp_addr_q[i] == rd_check_addr[DL-1:BO]) begin
            eh = 1'b1;
            ed = exp_q[i];
          end
        end
        check("rd_hit", rd_hit, eh);
        check("rd_hit_data", rd_hit_data, ed);
        if (!rst && l2_wr_valid === 1'b1 && l2_wr_ready) begin
          drain_addr_log.push_back(l2_wr_addr);
          drain_data_log.push_back(l2_wr_data);
        end
        if (full_flag === 1'b1) full_seen = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs are changed 1 time unit after the rising edge.
  task automatic to_drive();
    @(posedge clk_l2);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) to_drive();
  endtask

  // Present a packet and hold it until the ack cycle is seen; returns the
  // number of edges from presentation to the ack cycle.
  task automatic send(input logic [WA-1:0] a, input logic [DL-1:0] d, output int lat);
    int n;
    n       = 0;
    wb_req  = 1'b1;
    wb_data = {a, d};
    do begin
      to_drive();
      n++;
    end while (wb_ack !== 1'b1 && n < 64);
    check("ack_timeout", wb_ack, 1'b1);
    wb_req = 1'b0;
    lat    = n;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int            lat;
    logic [DL-1:0] t2_exp [5];
    logic [DL-1:0] t5_addr [3];
    logic [DL-1:0] t6_exp[$];
    logic [WA-1:0] wa;
    logic [1:0]    lo;

    rst           = 1'b1;
    wb_req        = 1'b0;
    wb_data       = '0;
    l2_wr_ready   = 1'b0;
    rd_check_addr = '0;
    tick(3);
    rst = 1'b0;

    // Reset state
    @(negedge clk_l2);
    check("rst_wb_ack", wb_ack, 1'b0);
    check("rst_full", full_flag, 1'b0);
    check("rst_empty", wb_empty, 1'b1);
    check("rst_valid", l2_wr_valid, 1'b0);
    to_drive();

    // T1: single packet, ack latency and head presentation
    send(30'h0000_0010, 32'h567, lat);
    check("t1_ack_latency", lat, 1);
    to_drive();
    @(negedge clk_l2);
    check("t1_valid", l2_wr_valid, 1'b1);
    check("t1_addr", l2_wr_addr, 32'h40);
    check("t1_data", l2_wr_data, 32'h567);
    to_drive();
    l2_wr_ready = 1'b1;
    to_drive();
    l2_wr_ready = 1'b0;
    @(negedge clk_l2);
    check("t1_empty_after_drain", wb_empty, 1'b1);
    to_drive();

    // T2: fill, refuse while full, accept the cycle after a pop
    drain_addr_log.delete();
    for (int i = 0; i < 4; i++) send(WA'(32'h10 + i), 32'h1000 + i, lat);
    @(negedge clk_l2);
    check("t2_full", full_flag, 1'b1);
    to_drive();
    wb_req  = 1'b1;
    wb_data = {WA'(32'h14), 32'h1004};
    repeat (3) begin
      @(negedge clk_l2);
      check("t2_no_ack_full", wb_ack, 1'b0);
      to_drive();
    end
    l2_wr_ready = 1'b1;
    to_drive();
    l2_wr_ready = 1'b0;
    @(negedge clk_l2);
    check("t2_no_ack_pop_cycle", wb_ack, 1'b0);
    to_drive();
    check("t2_ack_after_pop", wb_ack, 1'b1);
    wb_req      = 1'b0;
    l2_wr_ready = 1'b1;
    tick(6);
    l2_wr_ready = 1'b0;
    t2_exp = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h50};
    check("t2_drain_count", drain_addr_log.size(), 5);
    for (int i = 0; i < 5; i++) check("t2_drain_order", drain_addr_log[i], t2_exp[i]);

    // T3: coalesce into newest entry
    send(WA'(32'h10), 32'hA1, lat);
    send(WA'(32'h11), 32'hA2, lat);
    send(WA'(32'h11), 32'hABC, lat);
    rd_check_addr = 32'h44;
    @(negedge clk_l2);
    check("t3_count", dbg_count, 3'd2);
    check("t3_rd_hit", rd_hit, 1'b1);
    check("t3_rd_hit_data", rd_hit_data, 32'hABC);
    to_drive();
    l2_wr_ready = 1'b1;
    tick(3);
    l2_wr_ready = 1'b0;

    // T4: no merge with a single entry
    drain_data_log.delete();
    send(WA'(32'h10), 32'h222, lat);
    send(WA'(32'h10), 32'h111, lat);
    rd_check_addr = 32'h40;
    @(negedge clk_l2);
    check("t4_count", dbg_count, 3'd2);
    check("t4_rd_hit_data", rd_hit_data, 32'h111);
    to_drive();
    l2_wr_ready = 1'b1;
    tick(3);
    l2_wr_ready = 1'b0;
    check("t4_drain_count", drain_data_log.size(), 2);
    check("t4_drain_old", drain_data_log[0], 32'h222);
    check("t4_drain_new", drain_data_log[1], 32'h111);

    // T5: reset with 3 entries and ack pending, request held across reset
    send(WA'(32'h20), 32'hB0, lat);
    send(WA'(32'h21), 32'hB1, lat);
    send(WA'(32'h22), 32'hB2, lat);
    rst     = 1'b1;
    wb_req  = 1'b1;
    wb_data = {WA'(32'h23), 32'h777};
    to_drive();
    @(negedge clk_l2);
    check("t5_empty", wb_empty, 1'b1);
    check("t5_ack", wb_ack, 1'b0);
    check("t5_valid", l2_wr_valid, 1'b0);
    t5_addr = '{32'h80, 32'h84, 32'h88};
    for (int i = 0; i < 3; i++) begin
      rd_check_addr = t5_addr[i];
      #1;
      check("t5_rd_hit", rd_hit, 1'b0);
    end
    to_drive();
    rst = 1'b0;
    lat = 0;
    do begin
      to_drive();
      lat++;
    end while (wb_ack !== 1'b1 && lat < 20);
    check("t5_held_req_ack", wb_ack, 1'b1);
    wb_req = 1'b0;
    @(negedge clk_l2);
    check("t5_held_req_addr", l2_wr_addr, 32'h8C);
    to_drive();
    l2_wr_ready = 1'b1;
    tick(2);

    // T6: 12 back-to-back packets with the drain always ready
    drain_addr_log.delete();
    full_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      t6_exp.push_back(32'h400 + 32'(i) * 4);
      send(WA'(32'h100 + i), $urandom(), lat);
    end
    tick(3);
    check("t6_full_never", full_seen, 1'b0);
    check("t6_drain_count", drain_addr_log.size(), 12);
    for (int i = 0; i < 12; i++) check("t6_drain_order", drain_addr_log[i], t6_exp[i]);

    // Random phase: legal DL1 protocol, random back-pressure, rare resets
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!wb_req || wb_ack) begin
        if ($urandom_range(0, 2) != 0) begin
          wb_req  = 1'b1;
          wb_data = {WA'(32'h40 + $urandom_range(0, 5)), $urandom()};
        end else begin
          wb_req = 1'b0;
        end
      end
      l2_wr_ready   = 1'($urandom_range(0, 1));
      wa            = WA'(32'h40 + $urandom_range(0, 6));
      lo            = 2'($urandom_range(0, 3));
      rd_check_addr = {wa, lo};
      to_drive();
    end

    rst         = 1'b0;
    wb_req      = 1'b0;
    l2_wr_ready = 1'b1;
    tick(8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/l2_wb_receiver.md
Name: l2_wb_receiver

Overview:
- L2-side responder for the DL1 write-buffer handshake (`wb_req`/`wb_data`/`wb_ack`/`full_flag`).
- Accepts dirty-word write packets from DL1 and holds them in a small coalescing FIFO.
- Drains packets one at a time into the L2 data-array write port.
- Provides read-after-write forwarding so an L2 lookup never returns data older than a buffered write.

Parameters:
- DATA_LENGTH, 32, data and address width.
- BYTE_OFFSET, 2, byte-offset bits dropped from the packet address.
- WB_DEPTH, 4, FIFO entries; power of two, ≥2.

Ports:
- clk_l2  input  1  L2 clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- wb_req  input  1  DL1 packet valid; level signal, held until acknowledged.
- wb_data  input  2*DATA_LENGTH-BYTE_OFFSET  packet `{word_addr[DATA_LENGTH-1:BYTE_OFFSET], data[DATA_LENGTH-1:0]}`.
- wb_ack  output  1  one-cycle acceptance pulse to DL1.
- full_flag  output  1  registered; high when count == WB_DEPTH.
- wb_empty  output  1  registered; high when count == 0.
- l2_wr_valid  output  1  head entry presented to the L2 array.
- l2_wr_addr  output  DATA_LENGTH  head byte address: `{word_addr, BYTE_OFFSET zeros}`.
- l2_wr_data  output  DATA_LENGTH  head data.
- l2_wr_ready  input  1  L2 array accepts the write this cycle.
- rd_check_addr  input  DATA_LENGTH  L2 lookup byte address.
- rd_hit  output  1  combinational; some valid entry matches `rd_check_addr[DATA_LENGTH-1:BYTE_OFFSET]`.
- rd_hit_data  output  DATA_LENGTH  data of the newest matching entry; 0 when `rd_hit` = 0.

Behaviour:
- Reset values:
  - `wb_ack` = 0, `full_flag` = 0, `wb_empty` = 1, `l2_wr_valid` = 0.
  - Read/write pointers and count = 0; entry contents are don't-care.
- Reset mid-operation:
  - Every buffered packet is discarded and a pending ack is cancelled.
  - A `wb_req` held high across reset is captured normally once `rst` falls.
- Storage:
  - Circular FIFO; pointers are `$clog2(WB_DEPTH)` bits and wrap from WB_DEPTH-1 to 0.
  - Count is `$clog2(WB_DEPTH)+1` bits.
- Accept FSM, states IDLE and ACK:
  - IDLE: if `wb_req` && !`full_flag`, the packet is captured on this edge, `wb_ack` = 1 in the next cycle, and the FSM goes to ACK.
  - ACK: `wb_ack` = 1 for exactly this one cycle; `wb_req` is ignored; the FSM returns to IDLE.
  - The initiator drops or replaces `wb_req` after the ack cycle.
  - Minimum spacing between accepted packets is 2 cycles.
  - While full, `wb_req` waits in IDLE with `wb_ack` = 0.
- Coalescing:
  - Applies when the captured word address equals the newest entry's address and count ≥ 2.
  - The newest entry's data is overwritten; pointers and count are unchanged; `wb_ack` still pulses.
  - No merge when count == 1, because the head may be draining.
- Drain:
  - `l2_wr_valid` = !`wb_empty`; `l2_wr_addr`/`l2_wr_data` show the head entry.
  - On `l2_wr_valid` && `l2_wr_ready` the head is popped at the edge.
  - `l2_wr_valid` stays asserted until accepted; head contents are stable while valid.
- Simultaneous push and pop:
  - Count is unchanged; both pointers advance.
  - `full_flag` is registered, so a push is refused in the cycle the buffer is full even if a pop occurs that cycle; the request is accepted the following cycle.
- Flags:
  - `full_flag` and `wb_empty` are recomputed from the next-state count every edge.
- Forwarding:
  - Every valid entry is compared against `rd_check_addr`; the newest match wins (priority from tail-1 back to head).
  - An entry popped this cycle still forwards this cycle.
  - A packet captured this cycle does not forward until the next cycle.
- Latency:
  - Capture → `wb_ack`: 1 cycle.
  - Capture into empty FIFO → `l2_wr_valid`: 1 cycle.
  - Forwarding: 0 cycles.

Test Plan:
- Reset, then `wb_req`=1 with `wb_data` = `{30'h0000_0010, 32'h567}` → `wb_ack` pulses one cycle later; next cycle `l2_wr_valid`=1, `l2_wr_addr`=0x40, `l2_wr_data`=0x567.
- Hold `l2_wr_ready`=0 and send 4 distinct addresses 0x40/0x44/0x48/0x4C → `full_flag`=1 after the 4th capture; a 5th `wb_req` gets no `wb_ack` until one `l2_wr_ready` cycle, then it is acked; drain order is 0x40, 0x44, 0x48, 0x4C, 5th.
- With entries 0x40, 0x44 buffered, send 0x44/data 0xABC → acked, count stays 2, `rd_check_addr`=0x44 gives `rd_hit`=1 and `rd_hit_data`=0xABC.
- With only 0x40 buffered, send 0x40/0x111 → no merge, count = 2, drain writes the old data then 0x111; `rd_hit_data` for 0x40 = 0x111.
- Assert `rst` while 3 entries are held and an ack is pending → next cycle `wb_empty`=1, `wb_ack`=0, `l2_wr_valid`=0, `rd_hit`=0 for all prior addresses.
- Run 12 back-to-back pushes and pops with `l2_wr_ready`=1 → pointers wrap, all 12 packets drain in order with none lost, and `full_flag` never asserts.
